// File: rtl/out_layer_mac.sv
// out_layer_mac: output-layer neuron engine.
// Buffers one frame of N_HIDDEN activations, then walks a single MAC unit over
// every output neuron using weights/biases from an external synchronous ROM.
// Each neuron sum is rescaled by SHIFT and reduced to an 8-bit unsigned score.
// All scores are presented in parallel with a one-cycle score_valid pulse.
// Optional feature macro: OUT_LAYER_SAT_EN (clamp scores to [0,255]; when it is
// undefined, scores take the low byte of the rescaled sum).
module out_layer_mac #(
    parameter int N_HIDDEN = 16,
    parameter int N_OUT    = 10,
    parameter int ACC_W    = 24,
    parameter int SHIFT    = 7,
    parameter int ADDR_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 act_valid,
    input  logic [7:0]           act_data,
    output logic                 act_ready,
    output logic [ADDR_W-1:0]    w_addr,
    input  logic [7:0]           w_data,
    output logic                 busy,
    output logic [8*N_OUT-1:0]   score_flat,
    output logic                 score_valid
);

    localparam int N_SLOTS = N_OUT * (N_HIDDEN + 1);
    localparam int CNT_W   = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
    localparam int OUT_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N_HIDDEN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [OUT_W-1:0]  OUT_ONE   = OUT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_SLOTS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_MAC   = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    // Reduce a rescaled sum to an 8-bit score.
    function automatic logic [7:0] to_score(input logic signed [ACC_W-1:0] r);
        logic [7:0] res;
`ifdef OUT_LAYER_SAT_EN
        if (r[ACC_W-1]) begin
            res = 8'd0;
        end else if (|r[ACC_W-2:8]) begin
            res = 8'hFF;
        end else begin
            res = r[7:0];
        end
`else
        res = r[7:0];
`endif
        return res;
    endfunction

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;        // activation index / weight slot index
    logic [OUT_W-1:0]          out_q, out_d;        // neuron index of the slot being addressed
    logic                      bias_q, bias_d;      // addressed slot is the bias slot
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic                      ready_q, busy_q, sv_q;
    logic                      act_we_s;

    // Pipeline stage: describes the slot whose ROM word arrives this cycle.
    logic                      p_valid_q, p_bias_q;
    logic [CNT_W-1:0]          p_hid_q;
    logic [OUT_W-1:0]          p_out_q;

    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [16:0]        prod_s;
    logic signed [ACC_W-1:0]   prod_ext_s, bias_ext_s, sum_s, r_s;
    logic                      score_we_s;
    logic [7:0]                score_new_s;

    logic [7:0]                act_q   [N_HIDDEN];
    logic [7:0]                score_q [N_OUT];

    // Next-state logic for the control FSM, counters and ROM address.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        bias_d   = bias_q;
        addr_d   = addr_q;
        act_we_s = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (act_valid) begin
                    act_we_s = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = {CNT_W{1'b0}};
                        addr_d  = {ADDR_W{1'b0}};
                        state_d = S_MAC;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_MAC: begin
                if (addr_q == ADDR_LAST) begin
                    addr_d  = {ADDR_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    out_d   = {OUT_W{1'b0}};
                    bias_d  = 1'b0;
                    state_d = S_FLUSH;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                    if (bias_q) begin
                        bias_d = 1'b0;
                        cnt_d  = {CNT_W{1'b0}};
                        out_d  = out_q + OUT_ONE;
                    end else if (cnt_q == CNT_LAST) begin
                        bias_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_LOAD;
            end
            default: begin
                state_d = S_LOAD;
                cnt_d   = {CNT_W{1'b0}};
                out_d   = {OUT_W{1'b0}};
                bias_d  = 1'b0;
                addr_d  = {ADDR_W{1'b0}};
            end
        endcase
    end

    // MAC datapath: accumulate weight slots, finalise a neuron on its bias slot.
    always_comb begin
        prod_s      = $signed({9'd0, act_q[p_hid_q]}) * $signed({{9{w_data[7]}}, w_data});
        prod_ext_s  = {{(ACC_W-17){prod_s[16]}}, prod_s};
        bias_ext_s  = {{(ACC_W-8){w_data[7]}}, w_data};
        sum_s       = acc_q + (bias_ext_s <<< SHIFT);
        r_s         = sum_s >>> SHIFT;
        acc_d       = acc_q;
        score_we_s  = 1'b0;
        score_new_s = to_score(r_s);
        if (p_valid_q) begin
            if (p_bias_q) begin
                acc_d      = {ACC_W{1'b0}};
                score_we_s = 1'b1;
            end else begin
                acc_d = acc_q + prod_ext_s;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Control, pipeline and accumulator registers; outputs are driven from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_LOAD;
            cnt_q     <= {CNT_W{1'b0}};
            out_q     <= {OUT_W{1'b0}};
            bias_q    <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            sv_q      <= 1'b0;
            p_valid_q <= 1'b0;
            p_bias_q  <= 1'b0;
            p_hid_q   <= {CNT_W{1'b0}};
            p_out_q   <= {OUT_W{1'b0}};
            acc_q     <= {ACC_W{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            bias_q    <= bias_d;
            addr_q    <= addr_d;
            ready_q   <= (state_d == S_LOAD);
            busy_q    <= (state_d != S_LOAD);
            sv_q      <= (state_q == S_FLUSH);
            p_valid_q <= (state_q == S_MAC);
            p_bias_q  <= bias_q;
            p_hid_q   <= cnt_q;
            p_out_q   <= out_q;
            acc_q     <= acc_d;
        end
    end

    // Activation buffer and score registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_HIDDEN; k++) begin
                act_q[k] <= 8'd0;
            end
            for (int k = 0; k < N_OUT; k++) begin
                score_q[k] <= 8'd0;
            end
        end else begin
            if (act_we_s) begin
                act_q[cnt_q] <= act_data;
            end
            if (score_we_s) begin
                score_q[p_out_q] <= score_new_s;
            end
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_flat
        assign score_flat[8*g +: 8] = score_q[g];
    end

    assign act_ready   = ready_q;
    assign busy        = busy_q;
    assign score_valid = sv_q;
    assign w_addr      = addr_q;

endmodule

// File: tb/tb_out_layer_mac.sv
// Directed self-checking bench for out_layer_mac with a behavioural sync ROM.
module tb_out_layer_mac;
    localparam int NH = 16;
    localparam int NO = 10;
    localparam int AW = 8;
    localparam int LAT = 172;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              act_valid = 1'b0;
    logic [7:0]        act_data = 8'd0;
    logic              act_ready;
    logic [AW-1:0]     w_addr;
    logic [7:0]        w_data;
    logic              busy;
    logic [8*NO-1:0]   score_flat;
    logic              score_valid;

    logic [7:0]        rom [0:255];
    int                cyc = 0;
    int                sv_count = 0;
    int                n_cmp = 0;
    int                n_fail = 0;
    int                first_acc = 0;
    int                last_acc = 0;
    int                sv_cyc = 0;
    int                sv_before = 0;

    out_layer_mac dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .act_valid   (act_valid),
        .act_data    (act_data),
        .act_ready   (act_ready),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .busy        (busy),
        .score_flat  (score_flat),
        .score_valid (score_valid)
    );

    always #5 clk = ~clk;

    // Cycle index: constant between rising edges.
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM: data is valid the cycle after the address.
    always @(posedge clk) w_data <= rom[w_addr];

    // Count score_valid pulses, sampled away from the active edge.
    always @(negedge clk) if (score_valid === 1'b1) sv_count <= sv_count + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: every weight = wconst; mode 1: w[j][i] = j+1. Biases 0.
    task automatic set_rom(input int mode, input logic [7:0] wconst);
        for (int a = 0; a < 256; a++) rom[a] = 8'd0;
        for (int j = 0; j < NO; j++) begin
            for (int i = 0; i < NH; i++) begin
                rom[j*(NH+1)+i] = (mode == 1) ? 8'(j + 1) : wconst;
            end
        end
    endtask

    function automatic logic [8*NO-1:0] ramp(input int step);
        logic [8*NO-1:0] f;
        for (int j = 0; j < NO; j++) f[8*j +: 8] = 8'(step * (j + 1));
        return f;
    endfunction

    function automatic logic [8*NO-1:0] fill(input logic [7:0] v);
        logic [8*NO-1:0] f;
        for (int j = 0; j < NO; j++) f[8*j +: 8] = v;
        return f;
    endfunction

    task automatic check_scores(input string tag, input logic [8*NO-1:0] exp);
        for (int j = 0; j < NO; j++) begin
            chk($sformatf("%s score%0d", tag, j), 32'(score_flat[8*j +: 8]), 32'(exp[8*j +: 8]));
        end
    endtask

    // Stream N_HIDDEN activations base + step*i; returns at the negedge after the last accept.
    task automatic send_frame(input logic [7:0] base, input logic [7:0] step);
        int g;
        for (int i = 0; i < NH; i++) begin
            g = 0;
            act_valid = 1'b1;
            act_data  = base + 8'(step * i);
            while (act_ready !== 1'b1 && g < 400) begin
                @(negedge clk);
                g++;
            end
            if (g >= 400) chk("send act_ready timeout", 32'(act_ready), 32'd1);
            if (i == 0) first_acc = cyc;
            last_acc = cyc;
            @(negedge clk);
        end
        act_valid = 1'b0;
    endtask

    // Wait (bounded) for score_valid and check the latency from the last accept.
    task automatic wait_sv(input string tag);
        int n;
        n = 0;
        while (score_valid !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " score_valid seen"}, 32'(score_valid), 32'd1);
        chk({tag, " latency"}, 32'(cyc - last_acc), 32'(LAT));
        sv_cyc = cyc;
    endtask

    initial begin
        // Reset state
        set_rom(0, 8'd0);
        repeat (3) @(negedge clk);
        chk("rst act_ready", 32'(act_ready), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst score_valid", 32'(score_valid), 32'd0);
        chk("rst w_addr", 32'(w_addr), 32'd0);
        chk("rst score_flat", 32'(score_flat == '0), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle busy", 32'(busy), 32'd0);

        // Zero weights, b[3]=5: only score3 nonzero
        set_rom(0, 8'd0);
        rom[3*(NH+1)+NH] = 8'd5;
        send_frame(8'd3, 8'd11);
        chk("mac busy", 32'(busy), 32'd1);
        chk("mac act_ready", 32'(act_ready), 32'd0);
        chk("mac first addr", 32'(w_addr), 32'd0);
        @(negedge clk);
        chk("mac second addr", 32'(w_addr), 32'd1);
        wait_sv("bias");
        begin
            logic [8*NO-1:0] e;
            e = fill(8'd0);
            e[3*8 +: 8] = 8'd5;
            check_scores("bias", e);
        end
        chk("bias act_ready in sv cycle", 32'(act_ready), 32'd1);
        @(negedge clk);
        chk("sv pulse width", 32'(score_valid), 32'd0);
        chk("post busy", 32'(busy), 32'd0);
        chk("post w_addr", 32'(w_addr), 32'd0);

        // Activations 64, w[j][i]=j+1 -> 8,16,...,80
        set_rom(1, 8'd0);
        send_frame(8'd64, 8'd0);
        wait_sv("ramp");
        check_scores("ramp", ramp(8));

        // Large positive sum: 16*255*127 = 518160, >>>7 = 4048
        set_rom(0, 8'd127);
        send_frame(8'd255, 8'd0);
        wait_sv("pos");
`ifdef OUT_LAYER_SAT_EN
        check_scores("pos", fill(8'd255));
`else
        check_scores("pos", fill(8'd208));
`endif

        // Negative sum: -4080 >>> 7 = -32
        set_rom(0, 8'hFF);
        send_frame(8'd255, 8'd0);
        wait_sv("neg");
`ifdef OUT_LAYER_SAT_EN
        check_scores("neg", fill(8'd0));
`else
        check_scores("neg", fill(8'd224));
`endif

        // Reset 50 cycles into MAC
        set_rom(1, 8'd0);
        send_frame(8'd64, 8'd0);
        repeat (49) @(negedge clk);
        chk("pre-reset busy", 32'(busy), 32'd1);
        sv_before = sv_count;
        rst_n = 1'b0;
        #1;
        chk("midrst score_flat clear", 32'(score_flat == '0), 32'd1);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst act_ready", 32'(act_ready), 32'd1);
        chk("midrst w_addr", 32'(w_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("midrst no score_valid", 32'(sv_count), 32'(sv_before));
        chk("midrst idle busy", 32'(busy), 32'd0);
        chk("midrst score_flat held", 32'(score_flat == '0), 32'd1);
        send_frame(8'd64, 8'd0);
        wait_sv("after rst");
        check_scores("after rst", ramp(8));

        // Garbage on act_valid during MAC/FLUSH, then back-to-back frame
        @(negedge clk);
        send_frame(8'd64, 8'd0);
        act_valid = 1'b1;
        act_data  = 8'hFF;
        wait_sv("garbage");
        check_scores("garbage", ramp(8));
        send_frame(8'd32, 8'd0);
        chk("b2b first accept in sv cycle", 32'(first_acc), 32'(sv_cyc));
        wait_sv("b2b");
        check_scores("b2b", ramp(4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/out_layer_mac.md
# out_layer_mac

Output-layer neuron engine of the MLP. It buffers one frame of hidden-layer activations, then time-multiplexes a single multiply-accumulate unit over all output neurons, reading weights and biases from an external synchronous ROM. It rescales and clamps each sum to an 8-bit unsigned score, and presents all scores in parallel to the argmax stage with a one-cycle valid pulse.

## Interface
- N_HIDDEN, 16, number of hidden activations per frame
- N_OUT, 10, number of output neurons/scores
- ACC_W, 24, signed accumulator width
- SHIFT, 7, arithmetic right shift applied to the final sum (fixed-point rescale)
- ADDR_W, 8, ROM address width; must satisfy 2^ADDR_W >= N_OUT*(N_HIDDEN+1)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- act_valid  in  1  activation word present
- act_data  in  8  unsigned hidden activation
- act_ready  out  1  block accepts activation (high only in LOAD)
- w_addr  out  ADDR_W  ROM address
- w_data  in  8  signed ROM word, valid the cycle after w_addr is presented
- busy  out  1  high in MAC and FLUSH
- score_flat  out  8*N_OUT  score j at bits [8j+7:8j], unsigned
- score_valid  out  1  one-cycle pulse: score_flat updated

## Operation
- ROM map: weight w[j][i] at j*(N_HIDDEN+1)+i; bias b[j] at j*(N_HIDDEN+1)+N_HIDDEN.
- States: LOAD, MAC, FLUSH.
- LOAD: act_ready=1. Each act_valid&act_ready stores act_data at buffer index cnt, cnt++. When the N_HIDDEN-th word is accepted -> MAC, address counter = 0.
- MAC: w_addr = address counter, incremented every cycle from 0 to N_OUT*(N_HIDDEN+1)-1; after the last address -> FLUSH.
- Datapath, one cycle behind the address: a weight slot does acc += act[i]*w_data (8u x 8s -> 17-bit signed, sign-extended to ACC_W). A bias slot computes r = (acc + (b <<< SHIFT)) >>> SHIFT, writes the clamped r to score j, and clears acc.
- Clamp (see Configuration): r<0 -> 0, r>255 -> 255.
- FLUSH: one cycle consuming the final bias slot -> LOAD; score_valid=1 in that first LOAD cycle.
- act_valid outside LOAD is ignored; no data is lost or buffered.
- score_flat holds its value until the next frame's score write. Individual scores update during the frame; consumers sample on score_valid only.
- w_addr = 0 outside MAC.

## Timing
- Reset values: act_ready=1 (state LOAD), busy=0, score_valid=0, w_addr=0, score_flat=0, cnt=0, acc=0.
- Latency: last activation accepted at cycle T -> score_valid at cycle T + N_OUT*(N_HIDDEN+1) + 2 (172 with defaults).
- Back-to-back: a new frame's first activation is accepted in the score_valid cycle.
- Reset asserted mid-frame: all state clears immediately, no score_valid, and the partial frame is discarded. The first frame after release is computed from fresh data only.
- Accumulator does not saturate; ACC_W covers N_HIDDEN*255*128 plus the bias term with defaults.

## Configuration
- OUT_LAYER_SAT_EN defined: clamp r to [0,255] as above.
- Not defined: score = r[7:0] (two's-complement wrap, no clamp). Everything else is identical.

## Test plan
- Weights all 0, b[3]=5, other biases 0, any activations -> score_valid exactly 172 cycles after the last accept; score3=5, all others 0.
- Activations all 64, w[j][i]=j+1, biases 0 -> scores 8,16,24,...,80 for j=0..9.
- Activations all 255, weights 127, biases 0 -> every score 255 with OUT_LAYER_SAT_EN, 208 without. With weights -1 -> 0 with macro, 224 without.
- rst_n pulsed low 50 cycles into MAC -> score_flat=0, busy=0, act_ready=1, no score_valid. Next full frame per scenario 2 yields 8..80.
- act_valid held high through MAC/FLUSH with garbage data -> ignored, results unchanged. A second frame streamed starting in the score_valid cycle gives its correct scores 172 cycles after its last accept.
